// File: rtl/pc_sequencer.sv
// pc_sequencer: program counter with stall, jump, relative branch and optional return-address stack.
// Define PC_SEQ_RAS_EN to build the call/return stack; without it CALL acts as JUMP and RET as INC.
module pc_sequencer #(
  parameter int AW = 6,
  parameter logic [AW-1:0] RESET_PC = '0,
  parameter int RAS_DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          stall,
  input  logic [2:0]    op,
  input  logic [AW-1:0] target,
  input  logic [AW-1:0] offset,
  input  logic          cond,
  output logic [AW-1:0] pc,
  output logic [AW-1:0] pc_next,
  output logic          wrap,
  output logic          ras_full,
  output logic          ras_empty,
  output logic          ras_err
);
  logic [AW-1:0] pc_inc, pc_br, ras_top;
  logic is_jump, is_br, is_call, is_ret, pop, use_inc;
  assign pc_inc  = pc + 1'b1;
  assign pc_br   = pc + offset;
  assign is_jump = op == 3'd1;
  assign is_br   = op == 3'd2 && cond;
  assign is_call = op == 3'd3;
  assign is_ret  = op == 3'd4;
`ifdef PC_SEQ_RAS_EN
  localparam int IW  = RAS_DEPTH > 1 ? $clog2(RAS_DEPTH) : 1;
  localparam int SPW = $clog2(RAS_DEPTH + 1);
  logic [AW-1:0] ras [2**IW];
  logic [SPW-1:0] sp, top;
  logic push, err_set;
  assign top       = sp - 1'b1;
  assign ras_full  = sp == SPW'(RAS_DEPTH);
  assign ras_empty = sp == '0;
  assign ras_top   = ras[top[IW-1:0]];
  assign push      = !stall && is_call && !ras_full;
  assign pop       = !stall && is_ret && !ras_empty;
  assign err_set   = !stall && ((is_call && ras_full) || (is_ret && ras_empty));
  always_ff @(posedge clk) begin
    if (rst) begin
      sp      <= '0;
      ras_err <= 1'b0;
    end else begin
      if (push) begin
        ras[sp[IW-1:0]] <= pc_inc;
        sp <= sp + 1'b1;
      end else if (pop) sp <= top;
      if (err_set) ras_err <= 1'b1;
    end
  end
`else
  localparam int UNUSED_DEPTH = RAS_DEPTH;
  assign pop       = 1'b0;
  assign ras_top   = '0;
  assign ras_full  = 1'b0;
  assign ras_empty = 1'b1;
  assign ras_err   = 1'b0;
`endif
  // wrap only counts the +1 path, never a redirect that happens to land on 0
  assign use_inc = !stall && !(is_jump || is_call || is_br || pop);
  always_comb pc_next = stall ? pc : (is_jump || is_call) ? target : is_br ? pc_br : pop ? ras_top : pc_inc;
  always_ff @(posedge clk) begin
    if (rst) begin
      pc   <= RESET_PC;
      wrap <= 1'b0;
    end else begin
      pc   <= pc_next;
      wrap <= use_inc && &pc;
    end
  end
endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed test-plan sequences plus randomized ops checked against a queue-based model.
module tb_pc_sequencer;
  logic clk = 0, rst = 1, stall = 0, cond = 0;
  logic [2:0] op = 0;
  logic [5:0] target = 0, offset = 0;
  logic [5:0] pc, pc_next;
  logic wrap, ras_full, ras_empty, ras_err;
  int checks = 0, errors = 0;
  int m_pc = 0, m_err = 0, m_wrap = 0;
  int m_stack[$];
  bit checking = 0;
`ifdef PC_SEQ_RAS_EN
  localparam bit RAS = 1;
`else
  localparam bit RAS = 0;
`endif

  pc_sequencer #(.AW(6), .RESET_PC(6'd0), .RAS_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .stall(stall), .op(op), .target(target), .offset(offset), .cond(cond),
    .pc(pc), .pc_next(pc_next), .wrap(wrap), .ras_full(ras_full), .ras_empty(ras_empty), .ras_err(ras_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) if (checking) begin
    chk("pc", pc, m_pc);
    chk("wrap", wrap, m_wrap);
    chk("ras_err", ras_err, m_err);
    chk("ras_full", ras_full, RAS && m_stack.size() == 4);
    chk("ras_empty", ras_empty, !RAS || m_stack.size() == 0);
  end

  task automatic step(input bit r, input bit s, input int o, input int t, input int f, input bit c);
    int npc, nwrap;
    @(negedge clk);
    #2;
    rst = r; stall = s; op = 3'(o); target = 6'(t); offset = 6'(f); cond = c;
    nwrap = 0;
    if (r) begin
      npc = 0; m_stack.delete(); m_err = 0;
    end else if (s) npc = m_pc;
    else if (o == 1) npc = t;
    else if (o == 2 && c) npc = (m_pc + f) % 64;
    else if (o == 3) begin
      if (RAS) begin
        if (m_stack.size() < 4) m_stack.push_back((m_pc + 1) % 64);
        else m_err = 1;
      end
      npc = t;
    end else if (o == 4 && RAS && m_stack.size() > 0) npc = m_stack.pop_back();
    else begin
      if (o == 4 && RAS) m_err = 1;
      nwrap = m_pc == 63;
      npc = (m_pc + 1) % 64;
    end
    #1;
    if (!r) chk("pc_next", pc_next, npc);
    @(posedge clk);
    m_pc = npc; m_wrap = nwrap;
    #1;
  endtask

  task automatic inc(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    int wraps;
    step(1, 0, 0, 0, 0, 0);
    checking = 1;
    chk("reset_pc", pc, 0);
    chk("reset_empty", ras_empty, 1);
    chk("reset_full", ras_full, 0);
    wraps = 0;
    for (int i = 0; i < 66; i++) begin
      step(0, 0, 0, 0, 0, 0);
      wraps += wrap;
      if (i == 63) begin
        chk("wrap_to_0_pc", pc, 0);
        chk("wrap_pulse", wrap, 1);
      end
    end
    chk("after66_pc", pc, 2);
    chk("wrap_count", wraps, 1);
    step(0, 0, 1, 10, 0, 0);
    for (int i = 0; i < 3; i++) begin
      step(0, 1, 1, 40, 0, 0);
      chk("stall_pc", pc, 10);
    end
    inc(1);
    chk("after_stall", pc, 11);
    step(0, 0, 1, 20, 0, 0);
    step(0, 0, 2, 0, 'h3C, 1);
    chk("branch_back", pc, 16);
    step(0, 0, 1, 20, 0, 0);
    step(0, 0, 2, 0, 'h3C, 0);
    chk("branch_nt", pc, 21);
    step(0, 0, 1, 62, 0, 0);
    step(0, 0, 2, 0, 2, 1);
    chk("branch_to0_pc", pc, 0);
    chk("branch_to0_nowrap", wrap, 0);
    step(0, 0, 1, 2, 0, 0);
    if (RAS) begin
      step(0, 0, 3, 30, 0, 0);
      step(0, 0, 3, 40, 0, 0);
      step(0, 0, 3, 50, 0, 0);
      step(0, 0, 3, 60, 0, 0);
      chk("calls_full", ras_full, 1);
      step(0, 0, 3, 5, 0, 0);
      chk("overflow_pc", pc, 5);
      chk("overflow_err", ras_err, 1);
      step(0, 0, 4, 0, 0, 0); chk("ret1", pc, 51);
      step(0, 0, 4, 0, 0, 0); chk("ret2", pc, 41);
      step(0, 0, 4, 0, 0, 0); chk("ret3", pc, 31);
      step(0, 0, 4, 0, 0, 0); chk("ret4", pc, 3);
      chk("rets_empty", ras_empty, 1);
    end else begin
      step(0, 0, 3, 12, 0, 0);
      chk("call_as_jump", pc, 12);
      step(0, 0, 4, 0, 0, 0);
      chk("ret_as_inc", pc, 13);
      chk("no_err", ras_err, 0);
    end
    step(1, 0, 0, 0, 0, 0);
    step(0, 0, 1, 7, 0, 0);
    step(0, 0, 4, 0, 0, 0);
    chk("ret_empty_pc", pc, 8);
    chk("ret_empty_err", ras_err, RAS);
    step(1, 1, 3, 33, 0, 0);
    chk("rst_err", ras_err, 0);
    chk("rst_pc", pc, 0);
    for (int i = 0; i < 3000; i++)
      step($urandom_range(0, 49) == 0, $urandom_range(0, 7) == 0, $urandom_range(0, 7),
           $urandom_range(0, 63), $urandom_range(0, 63), $urandom_range(0, 1));
    @(negedge clk);
    checking = 0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
